// File: rtl/gobang_board_memory_pkg.sv
// Shared definitions for the gobang board store: cell encodings, the
// clear-sequencer state type and the flat-board cell index helper.
package gobang_pkg;

  localparam int CELL_EMPTY   = 0;
  localparam int CELL_BLACK   = 1;
  localparam int CELL_WHITE   = 2;
  localparam int CELL_ILLEGAL = 3;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  // Position of cell (x,y) in the flat board image, in cells.
  function automatic int cell_index(input int x, input int y, input int dim);
    return x * dim + y;
  endfunction

endpackage

// File: rtl/gobang_board_row.sv
// One board row: BOARD_DIM cell registers with a column-selected write
// and a whole-row clear that takes priority over the write.
module gobang_board_row
  import gobang_pkg::*;
#(
  parameter int BOARD_DIM = 16,
  parameter int COORD_W   = 4,
  parameter int CELL_W    = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        write_en,
  input  logic [COORD_W-1:0]          write_col,
  input  logic [CELL_W-1:0]           write_data,
  input  logic                        row_clear,
  output logic [BOARD_DIM*CELL_W-1:0] row_data
);

  generate
    for (genvar gi = 0; gi < BOARD_DIM; gi++) begin : g_cell
      logic [CELL_W-1:0] cell_reg;

      always_ff @(posedge clock) begin
        if (reset || row_clear) begin
          cell_reg <= CELL_W'(CELL_EMPTY);
        end else if (write_en && write_col == COORD_W'(gi)) begin
          cell_reg <= write_data;
        end
      end

      assign row_data[gi*CELL_W +: CELL_W] = cell_reg;
    end
  endgenerate

endmodule

// File: rtl/gobang_board_memory.sv
// Parametrised gobang board store: legality-checked write port, registered
// read port, row-by-row clear sequencer and a stone counter.
module gobang_board_memory
  import gobang_pkg::*;
#(
  parameter int BOARD_DIM = 16,
  parameter int COORD_W   = 4,
  parameter int CELL_W    = 2,
  localparam int COUNT_W  = $clog2(BOARD_DIM*BOARD_DIM+1)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  write_enable,
  input  logic [COORD_W-1:0]                    write_x,
  input  logic [COORD_W-1:0]                    write_y,
  input  logic [CELL_W-1:0]                     write_data,
  output logic                                  write_accept,
  output logic                                  write_reject,
  input  logic [COORD_W-1:0]                    read_x,
  input  logic [COORD_W-1:0]                    read_y,
  output logic [CELL_W-1:0]                     read_data,
  input  logic                                  clear_start,
  output logic                                  busy,
  output logic [COUNT_W-1:0]                    move_count,
  output logic                                  board_full,
  output logic [BOARD_DIM*BOARD_DIM*CELL_W-1:0] board_out
);

  localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;
  localparam int ROW_W     = BOARD_DIM * CELL_W;

  state_t             state_reg, state_next;
  logic [COORD_W-1:0] row_ptr_reg, row_ptr_next;
  logic [COUNT_W-1:0] move_count_reg, move_count_next;
  logic               write_accept_reg, write_reject_reg;
  logic [CELL_W-1:0]  read_data_reg, read_data_next;
  logic               clear_done;
  logic               write_in_range, write_legal, write_commit;
  logic [CELL_W-1:0]  cell_old;

  // Board storage, one row module per x coordinate.
  generate
    for (genvar gi = 0; gi < BOARD_DIM; gi++) begin : g_row
      logic row_we;
      logic row_clear;

      assign row_we    = write_commit && (write_x == COORD_W'(gi));
      assign row_clear = (state_reg == ST_CLEAR) && (row_ptr_reg == COORD_W'(gi));

      gobang_board_row #(
        .BOARD_DIM (BOARD_DIM),
        .COORD_W   (COORD_W),
        .CELL_W    (CELL_W)
      ) u_row (
        .clock      (clock),
        .reset      (reset),
        .write_en   (row_we),
        .write_col  (write_y),
        .write_data (write_data),
        .row_clear  (row_clear),
        .row_data   (board_out[gi*ROW_W +: ROW_W])
      );
    end
  endgenerate

  // Legality check against the committed board contents.
  always_comb begin
    write_in_range = (int'(write_x) < BOARD_DIM) && (int'(write_y) < BOARD_DIM);
    cell_old       = CELL_W'(CELL_EMPTY);
    if (write_in_range) begin
      cell_old = board_out[cell_index(int'(write_x), int'(write_y), BOARD_DIM)*CELL_W +: CELL_W];
    end

    write_legal = 1'b0;
    if (state_reg == ST_CLEAR || clear_start) begin
      write_legal = 1'b0;
    end else if (!write_in_range) begin
      write_legal = 1'b0;
    end else if (write_data == CELL_W'(CELL_ILLEGAL)) begin
      write_legal = 1'b0;
    end else if (write_data != CELL_W'(CELL_EMPTY)) begin
      write_legal = (cell_old == CELL_W'(CELL_EMPTY));
    end else begin
      write_legal = (cell_old != CELL_W'(CELL_EMPTY));
    end
    write_commit = write_enable && write_legal;
  end

  // Clear sequencer next state.
  always_comb begin
    state_next   = state_reg;
    row_ptr_next = row_ptr_reg;
    clear_done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (clear_start) begin
          state_next   = ST_CLEAR;
          row_ptr_next = '0;
        end
      end
      ST_CLEAR: begin
        if (row_ptr_reg == COORD_W'(BOARD_DIM-1)) begin
          state_next   = ST_IDLE;
          row_ptr_next = '0;
          clear_done   = 1'b1;
        end else begin
          row_ptr_next = row_ptr_reg + 1'b1;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        row_ptr_next = '0;
      end
    endcase
  end

  // Stone counter: accepted writes place a stone unless they write empty.
  always_comb begin
    move_count_next = move_count_reg;
    if (clear_done) begin
      move_count_next = '0;
    end else if (write_commit) begin
      if (write_data == CELL_W'(CELL_EMPTY)) begin
        move_count_next = move_count_reg - 1'b1;
      end else begin
        move_count_next = move_count_reg + 1'b1;
      end
    end
  end

  always_comb begin
    read_data_next = '0;
    if ((int'(read_x) < BOARD_DIM) && (int'(read_y) < BOARD_DIM)) begin
      read_data_next = board_out[cell_index(int'(read_x), int'(read_y), BOARD_DIM)*CELL_W +: CELL_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      row_ptr_reg      <= '0;
      move_count_reg   <= '0;
      write_accept_reg <= 1'b0;
      write_reject_reg <= 1'b0;
      read_data_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      row_ptr_reg      <= row_ptr_next;
      move_count_reg   <= move_count_next;
      write_accept_reg <= write_commit;
      write_reject_reg <= write_enable && !write_legal;
      read_data_reg    <= read_data_next;
    end
  end

  assign write_accept = write_accept_reg;
  assign write_reject = write_reject_reg;
  assign read_data    = read_data_reg;
  assign busy         = (state_reg == ST_CLEAR);
  assign move_count   = move_count_reg;
  assign board_full   = (move_count_reg == COUNT_W'(NUM_CELLS));

endmodule
